ram_dp: RTL and testbench
=========================

RAM_DP -- requirements
Module: ram_dp

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits; SHALL be a multiple of 8, at least 8.
REQ-002 Parameter ADDR_W, default 4, address width; depth SHALL be 2^ADDR_W words.
REQ-003 Parameter WR_MODE, default 0, same-address collision policy: 0 = read-old, 1 = read-new.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 ce  input  1  chip enable; when 0, no write and no read SHALL be accepted.
REQ-007 we  input  1  write request.
REQ-008 be  input  DATA_W/8  byte enables for the write; bit i covers data bits [8i+7:8i].
REQ-009 addr_w  input  ADDR_W  write address.
REQ-010 data_w  input  DATA_W  write data.
REQ-011 re  input  1  read request.
REQ-012 addr_r  input  ADDR_W  read address.
REQ-013 data_r  output  DATA_W  registered read data.
REQ-014 valid_r  output  1  one-cycle pulse marking new data on data_r.
REQ-015 clr  input  1  synchronous request to zero the whole array.
REQ-016 busy  output  1  high while the clear sweep runs.

Function
REQ-017 The controller SHALL have two states: CLEAR and IDLE.
REQ-018 In CLEAR, each cycle SHALL write all-zero to location cnt and then increment cnt. After writing location 2^ADDR_W-1, the controller SHALL enter IDLE. A full sweep therefore takes 2^ADDR_W cycles.
REQ-019 busy SHALL be 1 exactly while the state is CLEAR.
REQ-020 In IDLE, clr=1 SHALL enter CLEAR with cnt=0 on the next edge. clr=1 during CLEAR SHALL restart the sweep at cnt=0.
REQ-021 While busy=1, ce, we and re SHALL be ignored: no user write, valid_r=0, and data_r holds its value.
REQ-022 Write acceptance: IDLE, clr=0, ce=1 and we=1. On acceptance, only bytes with be[i]=1 SHALL be updated; other bytes keep their value. be all-zero SHALL make the write a no-op.
REQ-023 Read acceptance: IDLE, clr=0, ce=1 and re=1. data_r SHALL present mem[addr_r] one edge after acceptance, and valid_r SHALL be 1 in that same cycle only.
REQ-024 If no read is accepted, valid_r SHALL be 0 next cycle and data_r SHALL hold its last value.
REQ-025 A simultaneous read and write to the same address SHALL return:
- pre-write data when WR_MODE=0;
- when WR_MODE=1, per-byte merged data: data_w bytes where be=1, old bytes elsewhere.
REQ-026 A simultaneous read and write to different addresses SHALL operate independently, with no interaction.
REQ-027 Addresses SHALL be used modulo 2^ADDR_W; no out-of-range access is possible.
REQ-028 A request arriving in the same cycle as clr SHALL be dropped; the clear takes priority.

Reset
REQ-029 rst=1 SHALL immediately force: state=CLEAR, cnt=0, busy=1, valid_r=0, data_r=0.
REQ-030 Array contents are not reset directly. They SHALL be zeroed by the post-reset sweep, which starts on the first edge after rst falls.
REQ-031 rst asserted mid-sweep or mid-read SHALL abort the operation and restart per REQ-029/030. No pending valid_r SHALL survive.

Verification
REQ-032 Reset and sweep (ADDR_W=4): release rst -> busy=1 for exactly 16 cycles, then 0. Read of any address then returns 0, with valid_r=1 one cycle after re.
REQ-033 Byte-enable write (DATA_W=16): write 0xABCD with be=2'b11, then 0x1234 with be=2'b01 to address 3 -> read of address 3 returns 0xAB34.
REQ-034 Collision (DATA_W=8): mem[5]=0x11; same-cycle write 0x22 and read of address 5:
- WR_MODE=0 -> data_r=0x11;
- WR_MODE=1 -> data_r=0x22;
- a following read of address 5 returns 0x22 in both modes.
REQ-035 Clear: fill all locations with 0xFF. Pulse clr together with we (addr 0, 0xAA) -> write dropped, busy=1 for 2^ADDR_W cycles, every location reads 0x00. clr repeated at cycle 5 of the sweep -> busy extends to 5+16 cycles total.
REQ-036 Gating: ce=0 with we=1, re=1 -> memory unchanged, valid_r=0, data_r held. Requests during busy=1 -> same result.
REQ-037 Async reset mid-sweep at cnt=7 -> busy stays 1, data_r=0, valid_r=0 immediately. A fresh 16-cycle sweep runs after release.

Source files
------------

// File: rtl/ram_dp.sv
// Byte-enable 1W/1R RAM with registered read; a clear sweep zeroes the array after reset or clr.
// Read latency one cycle; requests are ignored (not queued) while busy.
module ram_dp #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int WR_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr_w,
  input  logic [DATA_W-1:0]   data_w,
  input  logic                re,
  input  logic [ADDR_W-1:0]   addr_r,
  output logic [DATA_W-1:0]   data_r,
  output logic                valid_r,
  input  logic                clr,
  output logic                busy
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_data_r;
  logic              r_valid_r;
  logic              w_idle;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [DATA_W-1:0] w_wr_merged;
  logic [DATA_W-1:0] w_rd_dat;

  assign w_idle   = (r_state == S_IDLE);
  assign w_wr_acc = w_idle & ~clr & ce & we;
  assign w_rd_acc = w_idle & ~clr & ce & re;

  assign busy    = (r_state == S_CLEAR);
  assign data_r  = r_data_r;
  assign valid_r = r_valid_r;

  always_comb begin
    w_wr_merged = r_mem[addr_w];
    for (int i = 0; i < NB; i++) begin
      if (be[i]) w_wr_merged[8*i +: 8] = data_w[8*i +: 8];
    end
  end

  // Read-new forwards the merged write word; read-old simply sees the array before the edge.
  always_comb begin
    w_rd_dat = r_mem[addr_r];
    if (WR_MODE == 1 && w_wr_acc && addr_w == addr_r) w_rd_dat = w_wr_merged;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (clr) begin
      w_state_nxt = S_CLEAR;
      w_cnt_nxt   = '0;
    end else if (r_state == S_CLEAR) begin
      w_cnt_nxt = r_cnt + 1'b1;
      if (r_cnt == '1) w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_CLEAR;
      r_cnt     <= '0;
      r_data_r  <= '0;
      r_valid_r <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_valid_r <= w_rd_acc;
      if (w_rd_acc) r_data_r <= w_rd_dat;
    end
  end

  // Array has no reset; the sweep owns it while clearing.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_acc) begin
      r_mem[addr_w] <= w_wr_merged;
    end
  end

endmodule

// File: tb/tb_ram_dp.sv
// Bench for ram_dp: read-old and read-new instances share stimulus and are checked against a word-level model.
module tb_ram_dp;
  logic        clk = 1'b0;
  logic        rst;
  logic        ce, we, re, clr;
  logic [1:0]  be;
  logic [3:0]  addr_w, addr_r;
  logic [15:0] data_w;
  logic [15:0] d0, d1;
  logic        v0, v1, b0, b1;

  int n_checks = 0;
  int n_errors = 0;
  int n;

  logic [15:0] m_mem [16];
  int          m_busy;
  logic [15:0] m_d0, m_d1;
  logic        m_v;

  always #5 clk = ~clk;

  ram_dp #(.DATA_W(16), .ADDR_W(4), .WR_MODE(0)) u_old (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .be(be), .addr_w(addr_w), .data_w(data_w),
    .re(re), .addr_r(addr_r), .data_r(d0), .valid_r(v0), .clr(clr), .busy(b0));

  ram_dp #(.DATA_W(16), .ADDR_W(4), .WR_MODE(1)) u_new (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .be(be), .addr_w(addr_w), .data_w(data_w),
    .re(re), .addr_r(addr_r), .data_r(d1), .valid_r(v1), .clr(clr), .busy(b1));

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] nw, input logic [1:0] b);
    merge = o;
    if (b[0]) merge[7:0]  = nw[7:0];
    if (b[1]) merge[15:8] = nw[15:8];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 16'h0;
    m_busy = 16;
    m_d0 = 16'h0;
    m_d1 = 16'h0;
    m_v  = 1'b0;
  endtask

  // Clear is modelled as an instant wipe plus a 16-cycle blackout for requests.
  task automatic model_step();
    logic [15:0] nw;
    if (rst) begin
      model_reset();
    end else if (clr) begin
      for (int i = 0; i < 16; i++) m_mem[i] = 16'h0;
      m_busy = 16;
      m_v = 1'b0;
    end else if (m_busy > 0) begin
      m_busy--;
      m_v = 1'b0;
    end else begin
      nw  = merge(m_mem[addr_w], data_w, be);
      m_v = ce & re;
      if (ce && re) begin
        m_d0 = m_mem[addr_r];
        m_d1 = (we && addr_w == addr_r) ? nw : m_mem[addr_r];
      end
      if (ce && we) m_mem[addr_w] = nw;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("busy_old", 16'(b0), 16'(m_busy > 0));
    check("busy_new", 16'(b1), 16'(m_busy > 0));
    check("valid_old", 16'(v0), 16'(m_v));
    check("valid_new", 16'(v1), 16'(m_v));
    check("data_old", d0, m_d0);
    check("data_new", d1, m_d1);
  endtask

  task automatic idle_in();
    ce = 1'b0; we = 1'b0; re = 1'b0; clr = 1'b0;
  endtask

  task automatic run_until_idle(output int cnt);
    cnt = 0;
    idle_in();
    while (b0 && cnt < 200) begin
      cycle();
      cnt++;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
    idle_in();
    ce = 1'b1; we = 1'b1; addr_w = a; data_w = d; be = b;
    cycle();
    idle_in();
  endtask

  task automatic rd(input logic [3:0] a);
    idle_in();
    ce = 1'b1; re = 1'b1; addr_r = a;
    cycle();
    idle_in();
  endtask

  initial begin
    rst = 1'b1; idle_in();
    be = 2'b00; addr_w = 4'h0; addr_r = 4'h0; data_w = 16'h0;
    model_reset();
    #2;
    check("rst_busy", 16'(b0), 16'h1);
    check("rst_valid", 16'(v0), 16'h0);
    check("rst_data", d1, 16'h0);
    repeat (2) cycle();
    #2 rst = 1'b0;
    run_until_idle(n);
    check("sweep_len", 16'(n), 16'd16);

    rd(4'd7);
    check("rd_after_sweep_valid", 16'(v0), 16'h1);
    check("rd_after_sweep_data", d0, 16'h0);
    cycle();
    check("valid_pulse_end", 16'(v0), 16'h0);

    wr(4'd3, 16'hABCD, 2'b11);
    wr(4'd3, 16'h1234, 2'b01);
    rd(4'd3);
    check("byte_en", d0, 16'hAB34);

    wr(4'd5, 16'h0011, 2'b11);
    ce = 1'b1; we = 1'b1; re = 1'b1; addr_w = 4'd5; addr_r = 4'd5; data_w = 16'h0022; be = 2'b11;
    cycle();
    check("coll_read_old", d0, 16'h0011);
    check("coll_read_new", d1, 16'h0022);
    rd(4'd5);
    check("coll_after_old", d0, 16'h0022);
    check("coll_after_new", d1, 16'h0022);

    for (int i = 0; i < 1500; i++) begin
      ce     = ($urandom_range(0, 3) != 0);
      we     = 1'($urandom);
      re     = 1'($urandom);
      be     = 2'($urandom);
      data_w = 16'($urandom);
      addr_w = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      addr_r = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      clr    = ($urandom_range(0, 63) == 0);
      cycle();
    end
    run_until_idle(n);

    for (int a = 0; a < 16; a++) wr(4'(a), 16'hFFFF, 2'b11);
    ce = 1'b1; we = 1'b1; addr_w = 4'd0; data_w = 16'h00AA; be = 2'b11; clr = 1'b1;
    cycle();
    run_until_idle(n);
    check("clr_len", 16'(n), 16'd16);
    for (int a = 0; a < 16; a++) begin
      rd(4'(a));
      check("clr_zero", d0, 16'h0);
    end
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    repeat (4) cycle();
    clr = 1'b1;
    cycle();
    run_until_idle(n);
    check("clr_restart_len", 16'(5 + n), 16'd21);

    wr(4'd5, 16'h5A5A, 2'b11);
    rd(4'd5);
    ce = 1'b0; we = 1'b1; re = 1'b1; addr_w = 4'd5; addr_r = 4'd5; data_w = 16'h0;
    cycle();
    check("gate_valid", 16'(v0), 16'h0);
    check("gate_hold", d0, 16'h5A5A);
    rd(4'd5);
    check("gate_mem", d0, 16'h5A5A);
    clr = 1'b1;
    cycle();
    clr = 1'b0; ce = 1'b1; we = 1'b1; re = 1'b1; data_w = 16'h1111; be = 2'b11;
    repeat (3) cycle();
    check("busy_gate_hold", d1, 16'h5A5A);
    run_until_idle(n);
    rd(4'd5);
    check("busy_gate_mem", d0, 16'h0);

    wr(4'd9, 16'h0F0F, 2'b11);
    rd(4'd9);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    repeat (7) cycle();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("arst_busy", 16'(b0), 16'h1);
    check("arst_data", d0, 16'h0);
    check("arst_valid", 16'(v1), 16'h0);
    cycle();
    #2 rst = 1'b0;
    run_until_idle(n);
    check("arst_sweep_len", 16'(n), 16'd16);
    rd(4'd9);
    check("arst_mem_zero", d0, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
